// File: rtl/regfile_csr_pkg.sv
// rtl/regfile_csr_pkg.sv - bus widths, CSR addresses and write masks for regfile_csr
// Counter CSR addresses are only writable when CSR_COUNTERS_EN is defined.
package regfile_csr_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int CSR_ADDR_BUS_W = 12;

  typedef logic [REG_BUS_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;
  typedef logic [CSR_ADDR_BUS_W-1:0] csr_addr_bus_t;

  localparam csr_addr_bus_t CSR_MSTATUS  = 12'h300;
  localparam csr_addr_bus_t CSR_MISA     = 12'h301;
  localparam csr_addr_bus_t CSR_MTVEC    = 12'h305;
  localparam csr_addr_bus_t CSR_MSCRATCH = 12'h340;
  localparam csr_addr_bus_t CSR_MEPC     = 12'h341;
  localparam csr_addr_bus_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_bus_t CSR_MHARTID  = 12'hF14;
  localparam csr_addr_bus_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_bus_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_bus_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_bus_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_bus_t CSR_CYCLE     = 12'hC00;
  localparam csr_addr_bus_t CSR_CYCLEH    = 12'hC80;
  localparam csr_addr_bus_t CSR_INSTRET   = 12'hC02;
  localparam csr_addr_bus_t CSR_INSTRETH  = 12'hC82;

  localparam reg_bus_t MSTATUS_WMASK  = 32'h0000_0088;
  localparam reg_bus_t XTVEC_LOW_MASK = 32'hFFFF_FFFC;
  localparam reg_bus_t MISA_DEFAULT   = 32'h4000_0100;

  function automatic logic csr_is_writable(input csr_addr_bus_t addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE: return 1'b1;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic reg_bus_t csr_wmask(input csr_addr_bus_t addr, input reg_bus_t data);
    case (addr)
      CSR_MSTATUS:          return data & MSTATUS_WMASK;
      CSR_MTVEC, CSR_MEPC:  return data & XTVEC_LOW_MASK;
      default:              return data;
    endcase
  endfunction

endpackage

// File: rtl/regfile_csr_counter64.sv
// rtl/regfile_csr_counter64.sv - 64-bit counter with per-half write ports
// A write to either half wins over the increment in the same cycle.
module counter64
  import regfile_csr_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 inc_en_in,
  input  logic                 wr_lo_en_in,
  input  logic                 wr_hi_en_in,
  input  logic [REG_BUS_W-1:0] wdata_in,
  output logic [63:0]          count_out
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_en_in) count_d[31:0] = wdata_in;
    if (wr_hi_en_in) count_d[63:32] = wdata_in;
    if (!wr_lo_en_in && !wr_hi_en_in && inc_en_in) count_d = count_q + 64'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/regfile_csr.sv
// rtl/regfile_csr.sv - 32x32 GPR file plus machine CSRs with same-cycle write bypass
// Optional mcycle/minstret counters are built only when CSR_COUNTERS_EN is defined.
module regfile_csr
  import regfile_csr_pkg::*;
#(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = MISA_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      we_in,
  input  logic [REG_ADDR_BUS_W-1:0] waddr_in,
  input  logic [REG_BUS_W-1:0]      wdata_in,
  input  logic                      read1_enable,
  input  logic [REG_ADDR_BUS_W-1:0] read1_address,
  output logic [REG_BUS_W-1:0]      read1_data,
  input  logic                      read2_enable,
  input  logic [REG_ADDR_BUS_W-1:0] read2_address,
  output logic [REG_BUS_W-1:0]      read2_data,
  input  logic                      csr_read1_enable,
  input  logic [CSR_ADDR_BUS_W-1:0] csr_read1_address,
  output logic [REG_BUS_W-1:0]      csr_read1_data,
  input  logic                      csr_we_in,
  input  logic [CSR_ADDR_BUS_W-1:0] csr_waddr_in,
  input  logic [REG_BUS_W-1:0]      csr_wdata_in,
  input  logic                      retire_in
);

  reg_bus_t gpr_q [32];
  reg_bus_t gpr_d [32];
  reg_bus_t mstatus_q, mstatus_d;
  reg_bus_t mtvec_q, mtvec_d;
  reg_bus_t mscratch_q, mscratch_d;
  reg_bus_t mepc_q, mepc_d;
  reg_bus_t mcause_q, mcause_d;

  logic     gpr_wr;
  logic     csr_wr;
  reg_bus_t csr_wval;
  reg_bus_t csr_stored;

  assign gpr_wr   = we_in && rdy_in && !rst_in && (waddr_in != '0);
  assign csr_wr   = csr_we_in && rdy_in && !rst_in;
  assign csr_wval = csr_wmask(csr_waddr_in, csr_wdata_in);

  always_comb begin
    gpr_d = gpr_q;
    if (gpr_wr) gpr_d[waddr_in] = wdata_in;
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (csr_wr) begin
      case (csr_waddr_in)
        CSR_MSTATUS:  mstatus_d  = csr_wval;
        CSR_MTVEC:    mtvec_d    = csr_wval;
        CSR_MSCRATCH: mscratch_d = csr_wval;
        CSR_MEPC:     mepc_d     = csr_wval;
        CSR_MCAUSE:   mcause_d   = csr_wval;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gpr_q      <= '{default: '0};
      mstatus_q  <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      gpr_q      <= gpr_d;
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  counter64 u_mcycle (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .inc_en_in   (rdy_in),
    .wr_lo_en_in (csr_wr && (csr_waddr_in == CSR_MCYCLE)),
    .wr_hi_en_in (csr_wr && (csr_waddr_in == CSR_MCYCLEH)),
    .wdata_in    (csr_wdata_in),
    .count_out   (mcycle)
  );

  counter64 u_minstret (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .inc_en_in   (rdy_in && retire_in),
    .wr_lo_en_in (csr_wr && (csr_waddr_in == CSR_MINSTRET)),
    .wr_hi_en_in (csr_wr && (csr_waddr_in == CSR_MINSTRETH)),
    .wdata_in    (csr_wdata_in),
    .count_out   (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire_in;
`endif

  always_comb begin
    csr_stored = '0;
    case (csr_read1_address)
      CSR_MSTATUS:  csr_stored = mstatus_q;
      CSR_MISA:     csr_stored = MISA_VALUE;
      CSR_MTVEC:    csr_stored = mtvec_q;
      CSR_MSCRATCH: csr_stored = mscratch_q;
      CSR_MEPC:     csr_stored = mepc_q;
      CSR_MCAUSE:   csr_stored = mcause_q;
      CSR_MHARTID:  csr_stored = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    csr_stored = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   csr_stored = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  csr_stored = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_stored = minstret[63:32];
`endif
      default:      csr_stored = '0;
    endcase
  end

  function automatic reg_bus_t gpr_port(input logic en, input reg_addr_bus_t addr,
                                        input reg_bus_t stored);
    if (rst_in || !rdy_in || !en || addr == '0) return '0;
    if (we_in && waddr_in == addr)              return wdata_in;
    return stored;
  endfunction

  always_comb begin
    read1_data = gpr_port(read1_enable, read1_address, gpr_q[read1_address]);
    read2_data = gpr_port(read2_enable, read2_address, gpr_q[read2_address]);
  end

  // Read-only addresses never bypass, so misa/mhartid keep their constants.
  always_comb begin
    csr_read1_data = '0;
    if (!rst_in && rdy_in && csr_read1_enable) begin
      if (csr_we_in && csr_waddr_in == csr_read1_address && csr_is_writable(csr_read1_address))
        csr_read1_data = csr_wval;
      else
        csr_read1_data = csr_stored;
    end
  end

endmodule

// File: tb/tb_regfile_csr.sv
// tb/tb_regfile_csr.sv - directed self-checking bench for regfile_csr
// Counter expectations follow CSR_COUNTERS_EN when it is defined for the build.
module tb_regfile_csr;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        we_in = 1'b0;
  logic [4:0]  waddr_in = '0;
  logic [31:0] wdata_in = '0;
  logic        read1_enable = 1'b1;
  logic [4:0]  read1_address = '0;
  logic [31:0] read1_data;
  logic        read2_enable = 1'b1;
  logic [4:0]  read2_address = '0;
  logic [31:0] read2_data;
  logic        csr_read1_enable = 1'b1;
  logic [11:0] csr_read1_address = '0;
  logic [31:0] csr_read1_data;
  logic        csr_we_in = 1'b0;
  logic [11:0] csr_waddr_in = '0;
  logic [31:0] csr_wdata_in = '0;
  logic        retire_in = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  regfile_csr dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .we_in             (we_in),
    .waddr_in          (waddr_in),
    .wdata_in          (wdata_in),
    .read1_enable      (read1_enable),
    .read1_address     (read1_address),
    .read1_data        (read1_data),
    .read2_enable      (read2_enable),
    .read2_address     (read2_address),
    .read2_data        (read2_data),
    .csr_read1_enable  (csr_read1_enable),
    .csr_read1_address (csr_read1_address),
    .csr_read1_data    (csr_read1_data),
    .csr_we_in         (csr_we_in),
    .csr_waddr_in      (csr_waddr_in),
    .csr_wdata_in      (csr_wdata_in),
    .retire_in         (retire_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_read1_address = a;
    settle();
    check(tag, csr_read1_data, exp);
  endtask

  initial begin
    tick();
    // reset edge taken; reset still high while a write is presented
    we_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'hAAAA_AAAA;
    read1_address = 5'd5; csr_read1_address = 12'h301;
    settle();
    check("rst_rd1_zero", read1_data, 32'h0);
    check("rst_csr_zero", csr_read1_data, 32'h0);
    tick();
    rst_in = 1'b0; we_in = 1'b0;
    settle();
    check("rst_write_discarded", read1_data, 32'h0);

    we_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'hDEAD_BEEF;
    settle();
    check("bypass_x5", read1_data, 32'hDEAD_BEEF);
    tick();
    we_in = 1'b0; read2_address = 5'd5;
    settle();
    check("stored_x5_p1", read1_data, 32'hDEAD_BEEF);
    check("stored_x5_p2", read2_data, 32'hDEAD_BEEF);

    we_in = 1'b1; waddr_in = 5'd0; wdata_in = 32'h1234;
    read1_address = 5'd0; read2_address = 5'd0;
    settle();
    check("x0_bypass_zero", read1_data, 32'h0);
    tick();
    we_in = 1'b0;
    settle();
    check("x0_p1", read1_data, 32'h0);
    check("x0_p2", read2_data, 32'h0);

    we_in = 1'b1; waddr_in = 5'd1; wdata_in = 32'h1111_1111;
    tick();
    rdy_in = 1'b0; wdata_in = 32'h2222_2222; read1_address = 5'd1;
    settle();
    check("rdy0_out_zero", read1_data, 32'h0);
    tick();
    rdy_in = 1'b1; we_in = 1'b0;
    settle();
    check("rdy0_no_write", read1_data, 32'h1111_1111);
    read1_enable = 1'b0;
    settle();
    check("rd_disabled", read1_data, 32'h0);
    read1_enable = 1'b1;

    csr_we_in = 1'b1; csr_waddr_in = 12'h305; csr_wdata_in = 32'h0000_1003;
    csr_rd("mtvec_bypass", 12'h305, 32'h0000_1000);
    tick();
    csr_we_in = 1'b0;
    csr_rd("mtvec_stored", 12'h305, 32'h0000_1000);
    csr_we_in = 1'b1; csr_waddr_in = 12'h300; csr_wdata_in = 32'hFFFF_FFFF;
    tick();
    csr_waddr_in = 12'h341; csr_wdata_in = 32'h1234_5677;
    tick();
    csr_waddr_in = 12'h340; csr_wdata_in = 32'hABCD_1234;
    tick();
    csr_waddr_in = 12'h342; csr_wdata_in = 32'h8000_000B;
    tick();
    csr_waddr_in = 12'h7C0; csr_wdata_in = 32'h5;
    csr_rd("unimpl_bypass", 12'h7C0, 32'h0);
    csr_waddr_in = 12'h301; csr_wdata_in = 32'h0;
    csr_rd("misa_ro_bypass", 12'h301, 32'h4000_0100);
    tick();
    csr_we_in = 1'b0;
    csr_rd("mstatus_mask", 12'h300, 32'h0000_0088);
    csr_rd("mepc_mask", 12'h341, 32'h1234_5674);
    csr_rd("mscratch", 12'h340, 32'hABCD_1234);
    csr_rd("mcause", 12'h342, 32'h8000_000B);
    csr_rd("misa", 12'h301, 32'h4000_0100);
    csr_rd("mhartid", 12'hF14, 32'h0);
    csr_rd("unimpl_read", 12'h7C0, 32'h0);

    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    repeat (10) tick();
    csr_rd("mcycle_10", 12'hB00, CNT ? 32'd10 : 32'd0);
    csr_rd("cycle_mirror_10", 12'hC00, CNT ? 32'd10 : 32'd0);

    csr_we_in = 1'b1; csr_waddr_in = 12'hB00; csr_wdata_in = 32'hFFFF_FFFF;
    csr_rd("mcycle_bypass", 12'hB00, CNT ? 32'hFFFF_FFFF : 32'h0);
    tick();
    csr_waddr_in = 12'hB80;
    csr_rd("mcycle_lo_held", 12'hB00, CNT ? 32'hFFFF_FFFF : 32'h0);
    tick();
    csr_we_in = 1'b0;
    csr_rd("mcycle_lo_max", 12'hB00, CNT ? 32'hFFFF_FFFF : 32'h0);
    csr_rd("mcycleh_max", 12'hB80, CNT ? 32'hFFFF_FFFF : 32'h0);
    tick();
    csr_rd("mcycle_wrap_lo", 12'hB00, 32'h0);
    csr_rd("mcycle_wrap_hi", 12'hB80, 32'h0);

    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    foreach (retire_pat[i]) begin
      retire_in = retire_pat[i];
      tick();
    end
    retire_in = 1'b0;
    csr_rd("minstret_3", 12'hB02, CNT ? 32'd3 : 32'd0);
    csr_rd("instret_mirror_3", 12'hC02, CNT ? 32'd3 : 32'd0);
    csr_rd("minstreth_0", 12'hB82, 32'h0);

    we_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'h7777_7777;
    csr_we_in = 1'b1; csr_waddr_in = 12'h340; csr_wdata_in = 32'h5555_5555;
    tick();
    rst_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'h9999_9999;
    tick();
    rst_in = 1'b0; we_in = 1'b0; csr_we_in = 1'b0;
    for (int r = 0; r < 32; r++) begin
      read1_address = r[4:0];
      settle();
      check($sformatf("gpr_reset_x%0d", r), read1_data, 32'h0);
    end
    csr_rd("mstatus_reset", 12'h300, 32'h0);
    csr_rd("mtvec_reset", 12'h305, 32'h0);
    csr_rd("mscratch_reset", 12'h340, 32'h0);
    csr_rd("mepc_reset", 12'h341, 32'h0);
    csr_rd("mcause_reset", 12'h342, 32'h0);
    csr_rd("mcycle_reset", 12'hB00, 32'h0);
    csr_rd("minstret_reset", 12'hB02, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  logic retire_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

endmodule
